// File: rtl/quad_encoder_gen.sv
// Multi-channel quadrature step generator with an Avalon-MM register interface.
// Each channel turns a signed pending step count into Gray-code A/B transitions,
// one transition every PERIOD+1 clocks, and tracks the emitted position.
module quad_encoder_gen #(
  parameter int pENCODERS  = 2,
  parameter int pDIV_WIDTH = 16
) (
  input  logic                          iCLK,
  input  logic                          iRESET,
  input  logic [$clog2(pENCODERS)+1:0]  iAVL_ADDRESS,
  input  logic                          iAVL_WRITE,
  input  logic [31:0]                   iAVL_WRITE_DATA,
  input  logic                          iAVL_READ,
  output logic [31:0]                   oAVL_READ_DATA,
  output logic [pENCODERS-1:0]          oENCODER_A,
  output logic [pENCODERS-1:0]          oENCODER_B
);

  localparam int CW = $clog2(pENCODERS);
  localparam logic [CW:0] NUM_CHAN = (CW+1)'(pENCODERS);

  localparam logic [1:0] REG_STEPS    = 2'd0;
  localparam logic [1:0] REG_PERIOD   = 2'd1;
  localparam logic [1:0] REG_POSITION = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  // Per-channel state
  logic [31:0]           pending  [pENCODERS];
  logic [31:0]           position [pENCODERS];
  logic [pDIV_WIDTH-1:0] period   [pENCODERS];
  logic [pDIV_WIDTH-1:0] divider  [pENCODERS];
  logic                  enable   [pENCODERS];
  logic [1:0]            phase    [pENCODERS];

  // Per-channel decoded strobes and next values
  logic                  emit     [pENCODERS];
  logic                  stepsWr  [pENCODERS];
  logic                  periodWr [pENCODERS];
  logic                  posWr    [pENCODERS];
  logic                  ctrlWr   [pENCODERS];
  logic                  abortWr  [pENCODERS];
  logic [31:0]           pendBase [pENCODERS];
  logic [31:0]           pendSum  [pENCODERS];
  logic [1:0]            phaseNxt [pENCODERS];

  logic [CW-1:0] chanSel;
  logic [1:0]    regSel;
  logic          chanValid;
  logic [31:0]   readMux;

  // Saturating signed 32-bit add
  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) begin
      return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return s[31:0];
  endfunction

  // Gray-code advance: forward 00->10->11->01->00, reverse runs the other way
  function automatic logic [1:0] stepPhase(input logic [1:0] cur, input logic neg);
    logic [1:0] nxt;
    case ({neg, cur})
      3'b0_00: nxt = 2'b10;
      3'b0_10: nxt = 2'b11;
      3'b0_11: nxt = 2'b01;
      3'b0_01: nxt = 2'b00;
      3'b1_00: nxt = 2'b01;
      3'b1_01: nxt = 2'b11;
      3'b1_11: nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Address split and channel range check
  always_comb begin
    chanSel   = iAVL_ADDRESS[CW+1:2];
    regSel    = iAVL_ADDRESS[1:0];
    chanValid = ({1'b0, chanSel} < NUM_CHAN);
  end

  // Per-channel write decode, emission condition and next-value computation
  always_comb begin
    for (int unsigned i = 0; i < pENCODERS; i++) begin
      stepsWr[i]  = 1'b0;
      periodWr[i] = 1'b0;
      posWr[i]    = 1'b0;
      ctrlWr[i]   = 1'b0;
      if (iAVL_WRITE && chanValid && (chanSel == CW'(i))) begin
        stepsWr[i]  = (regSel == REG_STEPS);
        periodWr[i] = (regSel == REG_PERIOD);
        posWr[i]    = (regSel == REG_POSITION);
        ctrlWr[i]   = (regSel == REG_CTRL);
      end
      abortWr[i]  = ctrlWr[i] && iAVL_WRITE_DATA[1];
      // An abort in the same cycle as an emission edge suppresses the step
      emit[i]     = enable[i] && (pending[i] != '0) && (divider[i] == '0) && !abortWr[i];
      pendBase[i] = pending[i];
      if (emit[i]) begin
        pendBase[i] = pending[i][31] ? pending[i] + 32'd1 : pending[i] - 32'd1;
      end
      pendSum[i]  = satAdd(pendBase[i], iAVL_WRITE_DATA);
      phaseNxt[i] = stepPhase(phase[i], pending[i][31]);
    end
  end

  // Channel registers, divider and phase state
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int unsigned i = 0; i < pENCODERS; i++) begin
        pending[i]  <= '0;
        position[i] <= '0;
        period[i]   <= '0;
        divider[i]  <= '0;
        enable[i]   <= 1'b0;
        phase[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < pENCODERS; i++) begin
        if (abortWr[i]) begin
          pending[i] <= '0;
        end else if (stepsWr[i]) begin
          pending[i] <= pendSum[i];
        end else if (emit[i]) begin
          pending[i] <= pendBase[i];
        end

        if (periodWr[i]) begin
          period[i] <= iAVL_WRITE_DATA[pDIV_WIDTH-1:0];
        end

        if (posWr[i]) begin
          position[i] <= iAVL_WRITE_DATA;
        end else if (emit[i]) begin
          position[i] <= pending[i][31] ? position[i] - 32'd1 : position[i] + 32'd1;
        end

        if (ctrlWr[i]) begin
          enable[i] <= iAVL_WRITE_DATA[0];
        end

        if (emit[i]) begin
          phase[i] <= phaseNxt[i];
        end

        if (!enable[i] || (pending[i] == '0) || emit[i]) begin
          divider[i] <= period[i];
        end else begin
          divider[i] <= divider[i] - 1'b1;
        end
      end
    end
  end

  // Read data selection
  always_comb begin
    readMux = '0;
    if (chanValid) begin
      case (regSel)
        REG_STEPS:    readMux = pending[chanSel];
        REG_PERIOD:   readMux = 32'(period[chanSel]);
        REG_POSITION: readMux = position[chanSel];
        default:      readMux = {26'd0, phase[chanSel], 1'b0,
                                 (pending[chanSel] != '0), 1'b0, enable[chanSel]};
      endcase
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oAVL_READ_DATA <= '0;
    end else if (iAVL_READ) begin
      oAVL_READ_DATA <= readMux;
    end
  end

  // Outputs come straight from the phase flops
  always_comb begin
    for (int unsigned i = 0; i < pENCODERS; i++) begin
      oENCODER_A[i] = phase[i][1];
      oENCODER_B[i] = phase[i][0];
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed self-checking bench for quad_encoder_gen (2 channels, 16-bit divider).
module tb_quad_encoder_gen;

  logic        iCLK;
  logic        iRESET;
  logic [2:0]  iAVL_ADDRESS;
  logic        iAVL_WRITE;
  logic [31:0] iAVL_WRITE_DATA;
  logic        iAVL_READ;
  logic [31:0] oAVL_READ_DATA;
  logic [1:0]  oENCODER_A;
  logic [1:0]  oENCODER_B;

  int checks = 0;
  int errors = 0;

  quad_encoder_gen #(.pENCODERS(2), .pDIV_WIDTH(16)) dut (
    .iCLK           (iCLK),
    .iRESET         (iRESET),
    .iAVL_ADDRESS   (iAVL_ADDRESS),
    .iAVL_WRITE     (iAVL_WRITE),
    .iAVL_WRITE_DATA(iAVL_WRITE_DATA),
    .iAVL_READ      (iAVL_READ),
    .oAVL_READ_DATA (oAVL_READ_DATA),
    .oENCODER_A     (oENCODER_A),
    .oENCODER_B     (oENCODER_B)
  );

  // 10 ns clock, rising edges at multiples of 10
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Compare and report
  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] abOf(input int ch);
    return {30'd0, oENCODER_A[ch], oENCODER_B[ch]};
  endfunction

  // Called right after a falling edge; the write lands on the next rising edge
  task automatic avlWrite(input logic [2:0] addr, input logic [31:0] data);
    iAVL_ADDRESS    = addr;
    iAVL_WRITE_DATA = data;
    iAVL_WRITE      = 1'b1;
    @(negedge iCLK);
    iAVL_WRITE      = 1'b0;
  endtask

  // Called right after a falling edge; returns the data registered on the next rising edge
  task automatic avlRead(input logic [2:0] addr, output logic [31:0] data);
    iAVL_ADDRESS = addr;
    iAVL_READ    = 1'b1;
    @(negedge iCLK);
    iAVL_READ    = 1'b0;
    data         = oAVL_READ_DATA;
  endtask

  task automatic waitFall(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Looped-back quadrature decoder watching channel 1
  int   decCount;
  logic [1:0] decPrev;
  always @(negedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      decCount = 0;
      decPrev  = 2'b00;
    end else begin
      logic [1:0] cur;
      cur = {oENCODER_A[1], oENCODER_B[1]};
      if (cur != decPrev) begin
        case ({decPrev, cur})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: decCount = decCount + 1;
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: decCount = decCount - 1;
          default: decCount = decCount + 1000;
        endcase
        decPrev = cur;
      end
    end
  end

  // Channel 0: 000 STEPS, 001 PERIOD, 010 POSITION, 011 CTRL; channel 1: 1xx
  initial begin
    logic [31:0] rd;
    iRESET          = 1'b0;
    iAVL_ADDRESS    = '0;
    iAVL_WRITE      = 1'b0;
    iAVL_WRITE_DATA = '0;
    iAVL_READ       = 1'b0;
    waitFall(3);
    iRESET = 1'b1;
    waitFall(1);

    // Reset state
    checkValue("rst outA", {30'd0, oENCODER_A}, 32'd0);
    checkValue("rst outB", {30'd0, oENCODER_B}, 32'd0);
    checkValue("rst rdata", oAVL_READ_DATA, 32'd0);
    avlRead(3'b001, rd); checkValue("rst period0", rd, 32'd0);
    avlRead(3'b111, rd); checkValue("rst ctrl1", rd, 32'd0);

    // Test 1: PERIOD=3, STEPS=+4, transitions every 4 clocks after E0
    avlWrite(3'b001, 32'd3);
    avlWrite(3'b011, 32'd1);
    avlWrite(3'b000, 32'd4);            // E0, now at E0+0.5
    begin
      logic [1:0] seq [4];
      logic [1:0] prev;
      seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
      prev = 2'b00;
      for (int k = 0; k < 4; k++) begin
        waitFall(3);
        checkValue($sformatf("t1 hold%0d", k), abOf(0), {30'd0, prev});
        waitFall(1);
        checkValue($sformatf("t1 step%0d", k), abOf(0), {30'd0, seq[k]});
        prev = seq[k];
      end
    end
    avlRead(3'b011, rd); checkValue("t1 ctrl", rd, 32'h0000_0001);
    avlRead(3'b010, rd); checkValue("t1 position", rd, 32'd4);
    avlRead(3'b000, rd); checkValue("t1 steps", rd, 32'd0);

    // Test 2: channel 1, PERIOD=0, STEPS=-2, one transition per clock
    avlWrite(3'b111, 32'd1);
    avlWrite(3'b100, 32'hFFFF_FFFE);    // E0
    checkValue("t2 ab0", abOf(1), 32'b00);
    waitFall(1); checkValue("t2 ab1", abOf(1), 32'b01);
    waitFall(1); checkValue("t2 ab2", abOf(1), 32'b11);
    waitFall(1); checkValue("t2 ab3", abOf(1), 32'b11);
    checkValue("t2 ch0 idle", abOf(0), 32'b00);
    avlRead(3'b110, rd); checkValue("t2 position", rd, 32'hFFFF_FFFE);
    checkValue("t2 decoder", 32'(decCount), 32'hFFFF_FFFE);

    // Test 3: channel 0 disabled, saturation of STEPS
    avlWrite(3'b011, 32'd0);
    avlWrite(3'b000, 32'h7FFF_FFFF);
    avlWrite(3'b000, 32'h7FFF_FFFF);
    avlRead(3'b000, rd); checkValue("t3 sat pos", rd, 32'h7FFF_FFFF);
    avlWrite(3'b000, 32'h8000_0000);
    avlRead(3'b000, rd); checkValue("t3 minus1", rd, 32'hFFFF_FFFF);
    waitFall(2);
    checkValue("t3 rdata hold", oAVL_READ_DATA, 32'hFFFF_FFFF);
    checkValue("t3 out frozen", abOf(0), 32'b00);
    avlRead(3'b011, rd); checkValue("t3 ctrl busy", rd, 32'h0000_0004);
    avlWrite(3'b011, 32'd2);            // abort, stay disabled
    avlRead(3'b000, rd); checkValue("t3 abort steps", rd, 32'd0);

    // Test 4: sign reversal written on an emission edge
    avlWrite(3'b010, 32'd0);
    avlWrite(3'b011, 32'd1);
    avlWrite(3'b000, 32'd6);            // E0, t=0
    waitFall(3); checkValue("t4 t3", abOf(0), 32'b00);
    waitFall(1); checkValue("t4 t4", abOf(0), 32'b10);
    waitFall(3);                        // t=7
    avlWrite(3'b000, 32'hFFFF_FFF9);    // lands on E0+8 with pending=5
    checkValue("t4 t8 fwd", abOf(0), 32'b11);
    avlRead(3'b000, rd);                // t=9
    checkValue("t4 pending", rd, 32'hFFFF_FFFD);
    waitFall(2); checkValue("t4 t11", abOf(0), 32'b11);
    waitFall(1); checkValue("t4 t12 rev", abOf(0), 32'b10);
    waitFall(4); checkValue("t4 t16 rev", abOf(0), 32'b00);
    waitFall(4); checkValue("t4 t20 rev", abOf(0), 32'b01);
    waitFall(4); checkValue("t4 t24 done", abOf(0), 32'b01);
    avlRead(3'b010, rd); checkValue("t4 position", rd, 32'hFFFF_FFFF);
    avlRead(3'b011, rd); checkValue("t4 ctrl", rd, 32'h0000_0011);

    // Test 5: PERIOD change applies at next reload, then ABORT freezes
    avlWrite(3'b000, 32'd10);           // E0, t=0
    waitFall(4); checkValue("t5 t4", abOf(0), 32'b00);
    waitFall(1);                        // t=5
    avlWrite(3'b001, 32'd1);            // t=6
    waitFall(1); checkValue("t5 t7 old period", abOf(0), 32'b00);
    waitFall(1); checkValue("t5 t8", abOf(0), 32'b10);
    waitFall(1); checkValue("t5 t9", abOf(0), 32'b10);
    waitFall(1); checkValue("t5 t10 new period", abOf(0), 32'b11);
    avlWrite(3'b011, 32'd3);            // abort at t=11, keep enabled
    waitFall(4); checkValue("t5 frozen", abOf(0), 32'b11);
    avlRead(3'b011, rd); checkValue("t5 ctrl", rd, 32'h0000_0031);
    avlRead(3'b000, rd); checkValue("t5 steps", rd, 32'd0);

    // Test 6: asynchronous reset mid-run on channel 1
    avlWrite(3'b100, 32'd100);
    waitFall(3);
    checkValue("t6 running", {31'd0, (abOf(1) != 32'b11)}, 32'd1);
    #2 iRESET = 1'b0;
    #1;
    checkValue("t6 async A", {30'd0, oENCODER_A}, 32'd0);
    checkValue("t6 async B", {30'd0, oENCODER_B}, 32'd0);
    checkValue("t6 async rdata", oAVL_READ_DATA, 32'd0);
    waitFall(2);
    iRESET = 1'b1;
    waitFall(1);
    for (int a = 0; a < 8; a++) begin
      avlRead(3'(a), rd);
      checkValue($sformatf("t6 reg%0d", a), rd, 32'd0);
    end
    waitFall(3);
    checkValue("t6 idle", {28'd0, oENCODER_A, oENCODER_B}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
